// File: rtl/ndn_pkg.sv
// Shared NDN router constants and types.
// Packet sizes are derived from field widths.
package ndn_pkg;

  localparam int META_W   = 8;
  localparam int PREFIX_W = 64;
  localparam int DATA_W   = 256;

  localparam int INTEREST_BYTES = (META_W + PREFIX_W) / 8;
  localparam int DATA_BYTES     = (META_W + PREFIX_W + DATA_W) / 8;

  localparam int IDX_W = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_STROBE,
    DR_SEND
  } drain_state_e;

endpackage

// File: rtl/spi_rx_framer_if.sv
// SPI pins in, FIB byte stream and status out.
// master = SPI/FIB side, slave = framer.
interface spi_rx_framer_if;

  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       RX_valid;
  logic [7:0] data_SPI_to_FIB;
  logic       rx_drop;
  logic       rx_busy;

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n,
    input  RX_valid, data_SPI_to_FIB,
    input  rx_drop, rx_busy
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n,
    output RX_valid, data_SPI_to_FIB,
    output rx_drop, rx_busy
  );

endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte deserializer, MSB first.
// Synchronizes the pins and edge-detects sclk.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       cs_abort_o,
  output logic       cs_end_o
);

  logic [SYNC_STAGES-1:0] sclk_sq;
  logic [SYNC_STAGES-1:0] mosi_sq;
  logic [SYNC_STAGES-1:0] cs_sq;
  logic       sclk_prev_q, cs_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       sclk_s, mosi_s, cs_s, rise;

  assign sclk_s = sclk_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];
  assign cs_s   = cs_sq[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;

  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    if (cs_s) begin
      cnt_d = '0;
    end else if (rise) begin
      shift_d      = {shift_q[5:0], mosi_s};
      cnt_d        = cnt_q + 3'd1;
      byte_valid_o = (cnt_q == 3'd7);
    end
  end

  assign byte_o     = {shift_q, mosi_s};
  assign cs_end_o   = cs_s & ~cs_prev_q;
  assign cs_abort_o = cs_end_o & (cnt_q != 3'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sq     <= '0;
      mosi_sq     <= '0;
      cs_sq       <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
    end else begin
      sclk_sq     <= {sclk_sq[SYNC_STAGES-2:0], sclk_i};
      mosi_sq     <= {mosi_sq[SYNC_STAGES-2:0], mosi_i};
      cs_sq       <= {cs_sq[SYNC_STAGES-2:0], cs_n_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
    end
  end

endmodule

// File: rtl/spi_rx_framer.sv
// Frames SPI bytes into interest/data packets and
// drains them from ping-pong buffers to the FIB.
module spi_rx_framer
  import ndn_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DATA_FLAG_BIT = 7
) (
  input logic clk,
  input logic rst,
  spi_rx_framer_if.slave bus
);

  logic       byte_valid, cs_abort, cs_end;
  logic [7:0] rx_byte;

  logic [7:0] buf_q [2][DATA_BYTES];
  logic       fill_sel_q, last_q;
  logic       dropping_q, drop_q;
  logic [IDX_W-1:0] idx_q, len_q;
  logic [IDX_W-1:0] new_len, cur_len;
  logic [1:0][IDX_W-1:0] blen_q;
  logic [1:0] full_q, full_d, free_vec;
  logic       start_drop, cs_drop, wr_en, done;

  drain_state_e     state_q, state_d;
  logic             dsel_q, dsel_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic             rx_valid;
  logic [7:0]       rx_data;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte_rx (
    .clk_i        (clk),
    .rst_i        (rst),
    .sclk_i       (bus.spi_sclk),
    .mosi_i       (bus.spi_mosi),
    .cs_n_i       (bus.spi_cs_n),
    .byte_valid_o (byte_valid),
    .byte_o       (rx_byte),
    .cs_abort_o   (cs_abort),
    .cs_end_o     (cs_end)
  );

  // Length comes straight from byte 0 while it is being written
  always_comb begin
    new_len = rx_byte[DATA_FLAG_BIT] ? IDX_W'(DATA_BYTES)
                                     : IDX_W'(INTEREST_BYTES);
    cur_len = (idx_q == '0) ? new_len : len_q;
    start_drop = byte_valid && !dropping_q &&
                 (idx_q == '0) && (|full_q);
    wr_en   = byte_valid && !dropping_q && !start_drop;
    done    = wr_en && (idx_q + IDX_W'(1) == cur_len);
    cs_drop = cs_end && !dropping_q &&
              (cs_abort || idx_q != '0);
    full_d  = full_q & ~free_vec;
    if (done) full_d[fill_sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_sel_q <= 1'b0;
      last_q     <= 1'b0;
      dropping_q <= 1'b0;
      drop_q     <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      blen_q     <= '0;
      full_q     <= '0;
    end else begin
      drop_q <= start_drop || cs_drop;
      full_q <= full_d;
      if (cs_end) begin
        idx_q      <= '0;
        dropping_q <= 1'b0;
      end else if (start_drop) begin
        dropping_q <= 1'b1;
        len_q      <= new_len;
        idx_q      <= IDX_W'(1);
      end else if (dropping_q && byte_valid) begin
        if (idx_q + IDX_W'(1) == len_q) begin
          dropping_q <= 1'b0;
          idx_q      <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else if (wr_en) begin
        len_q <= cur_len;
        if (done) begin
          idx_q              <= '0;
          fill_sel_q         <= ~fill_sel_q;
          last_q             <= fill_sel_q;
          blen_q[fill_sel_q] <= cur_len;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[fill_sel_q][idx_q] <= rx_byte;
  end

  // With both buffers full the older one is the one not last filled
  always_comb begin
    state_d  = state_q;
    dsel_d   = dsel_q;
    oidx_d   = oidx_q;
    free_vec = '0;
    rx_valid = 1'b0;
    rx_data  = '0;
    unique case (state_q)
      DR_IDLE: begin
        if (|full_q) begin
          state_d = DR_STROBE;
          dsel_d  = (&full_q) ? ~last_q : full_q[1];
          oidx_d  = '0;
        end
      end
      DR_STROBE: begin
        rx_valid = 1'b1;
        state_d  = DR_SEND;
      end
      DR_SEND: begin
        rx_data = buf_q[dsel_q][oidx_q];
        if (oidx_q == blen_q[dsel_q] - IDX_W'(1)) begin
          free_vec[dsel_q] = 1'b1;
          state_d          = DR_IDLE;
        end else begin
          oidx_d = oidx_q + IDX_W'(1);
        end
      end
      default: state_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DR_IDLE;
      dsel_q  <= 1'b0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
      oidx_q  <= oidx_d;
    end
  end

  assign bus.RX_valid        = rx_valid;
  assign bus.data_SPI_to_FIB = rx_data;
  assign bus.rx_drop         = drop_q;
  assign bus.rx_busy         = |full_q;

endmodule

// File: tb/tb_spi_rx_framer.sv
// Directed + random SPI packets against a queue model
// of delivered FIB bursts.
module tb_spi_rx_framer;

  localparam int HP = 4;

  logic clk = 1'b0;
  logic rst;

  spi_rx_framer_if bus ();

  spi_rx_framer #(
    .SYNC_STAGES   (2),
    .DATA_FLAG_BIT (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int exp_pkts  = 0;
  int exp_drops = 0;

  int pkt_cnt    = 0;
  int drop_cnt   = 0;
  int strobe_cnt = 0;
  int proto_err  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Monitor: collect each burst; length follows the meta flag
  initial begin : monitor
    logic [7:0] cur [$];
    int  need;
    bit  coll;
    bit  prev_drop;
    coll = 0;
    need = 0;
    prev_drop = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        coll = 0;
        cur.delete();
        prev_drop = 0;
      end else begin
        if (bus.rx_drop) begin
          drop_cnt++;
          if (prev_drop) proto_err++;
        end
        prev_drop = bus.rx_drop;
        if (coll) begin
          if (bus.RX_valid) proto_err++;
          if (!bus.rx_busy) proto_err++;
          if (cur.size() == 0)
            need = bus.data_SPI_to_FIB[7] ? 41 : 9;
          cur.push_back(bus.data_SPI_to_FIB);
          if (cur.size() == need) begin
            foreach (cur[i]) obs_q.push_back(cur[i]);
            cur.delete();
            pkt_cnt++;
            coll = 0;
          end
        end else begin
          if (bus.data_SPI_to_FIB !== 8'h00) proto_err++;
          if (bus.RX_valid) begin
            strobe_cnt++;
            coll = 1;
            if (!bus.rx_busy) proto_err++;
          end
        end
      end
    end
  end

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    repeat (HP) @(negedge clk);
    bus.spi_sclk = 1'b1;
    repeat (HP) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic spi_bits(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = tx_q[i / 8];
      spi_bit(b[7 - (i % 8)]);
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (3 * HP) @(negedge clk);
  endtask

  task automatic build(input bit is_data);
    tx_q.delete();
    tx_q.push_back({is_data, 7'($urandom)});
    repeat (is_data ? 40 : 8) tx_q.push_back(8'($urandom));
  endtask

  task automatic build_interest30();
    tx_q = '{8'h30, 8'h00, 8'h00, 8'hFF, 8'hFF,
             8'h00, 8'h00, 8'hFF, 8'hFF};
  endtask

  task automatic send_tx(input bit expect_it);
    if (expect_it) begin
      foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
      exp_pkts++;
    end
    spi_bits(8 * tx_q.size());
  endtask

  task automatic wait_pkts(input int target);
    int n;
    n = 0;
    while (pkt_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_count", 64'(pkt_cnt), 64'(target));
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(obs_q[i]),
          64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    int s0;
    int p0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_rx_valid", 64'(bus.RX_valid), 64'd0);
    chk("rst_data", 64'(bus.data_SPI_to_FIB), 64'd0);
    chk("rst_drop", 64'(bus.rx_drop), 64'd0);
    chk("rst_busy", 64'(bus.rx_busy), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed interest packet
    cs_low();
    build_interest30();
    send_tx(1'b1);
    cs_high();
    wait_pkts(exp_pkts);
    check_rx("interest");
    chk("interest_strobes", 64'(strobe_cnt), 64'd1);

    // Directed data packet
    cs_low();
    tx_q = '{8'h80, 8'h01, 8'h23, 8'h45, 8'h67,
             8'h89, 8'hAB, 8'hCD, 8'hEF};
    for (int i = 0; i < 32; i++) tx_q.push_back(8'(i));
    send_tx(1'b1);
    cs_high();
    wait_pkts(exp_pkts);
    check_rx("data");

    // Abort 5 bits into byte 3, then a clean packet
    s0 = strobe_cnt;
    cs_low();
    build_interest30();
    spi_bits(3 * 8 + 5);
    exp_drops++;
    cs_high();
    repeat (20) @(negedge clk);
    chk("abort_drops", 64'(drop_cnt), 64'(exp_drops));
    chk("abort_no_strobe", 64'(strobe_cnt), 64'(s0));
    cs_low();
    build_interest30();
    send_tx(1'b1);
    cs_high();
    wait_pkts(exp_pkts);
    check_rx("after_abort");

    // Back-to-back with chip select held low
    s0 = strobe_cnt;
    cs_low();
    build(1'b0);
    send_tx(1'b1);
    build(1'b0);
    send_tx(1'b1);
    cs_high();
    wait_pkts(exp_pkts);
    check_rx("b2b");
    chk("b2b_strobes", 64'(strobe_cnt), 64'(s0 + 2));
    chk("b2b_busy_end", 64'(bus.rx_busy), 64'd0);

    // Random packets, optional trailing partial packet
    for (int it = 0; it < 5; it++) begin
      int np;
      bit is_d;
      cs_low();
      np = $urandom_range(1, 2);
      for (int p = 0; p < np; p++) begin
        build($urandom_range(0, 3) == 0);
        send_tx(1'b1);
      end
      if ($urandom_range(0, 1) == 1) begin
        is_d = ($urandom_range(0, 3) == 0);
        build(is_d);
        spi_bits($urandom_range(1, 8 * tx_q.size() - 1));
        exp_drops++;
      end
      cs_high();
      wait_pkts(exp_pkts);
      chk("rnd_drops", 64'(drop_cnt), 64'(exp_drops));
      check_rx($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a data burst
    s0 = strobe_cnt;
    p0 = pkt_cnt;
    cs_low();
    build(1'b1);
    fork
      begin
        send_tx(1'b0);
      end
      begin
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 20000) begin
          @(negedge clk);
          seen = bus.RX_valid;
          n++;
        end
        chk("rst_burst_strobe", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        chk("rst_burst_byte4", 64'(bus.data_SPI_to_FIB),
            64'(tx_q[4]));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_burst_valid", 64'(bus.RX_valid), 64'd0);
        chk("rst_burst_data",
            64'(bus.data_SPI_to_FIB), 64'd0);
        chk("rst_burst_busy", 64'(bus.rx_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    cs_high();
    repeat (200) @(negedge clk);
    chk("rst_no_restrobe", 64'(strobe_cnt), 64'(s0 + 1));
    chk("rst_no_pkt", 64'(pkt_cnt), 64'(p0));
    chk("rst_idle_data", 64'(bus.data_SPI_to_FIB), 64'd0);
    chk("rst_idle_busy", 64'(bus.rx_busy), 64'd0);

    chk("protocol", 64'(proto_err), 64'd0);
    chk("total_drops", 64'(drop_cnt), 64'(exp_drops));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_framer.md
# spi_rx_framer

Upstream receive stage of the NDN router that feeds `fib_table`. It deserializes bytes from an external SPI master (mode 0, MSB first), frames them into interest packets (9 bytes) or data packets (41 bytes), and buffers each complete packet. Each buffered packet then goes to the FIB as a one-cycle `RX_valid` strobe followed by a contiguous burst of one byte per clock on `data_SPI_to_FIB`. Two packet buffers in ping-pong let one packet fill from SPI while the other drains to the FIB.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `spi_sclk`, `spi_mosi` and `spi_cs_n`.
- `DATA_FLAG_BIT`, default 7: metadata bit that selects packet type (1 = data, 0 = interest).

- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sclk`  in  1  SPI clock, asynchronous to `clk`.
- `spi_mosi`  in  1  SPI data; sampled on the rising edge of `spi_sclk`.
- `spi_cs_n`  in  1  SPI chip select, active low.
- `RX_valid`  out  1  one-cycle start-of-packet strobe to the FIB.
- `data_SPI_to_FIB`  out  8  packet byte stream to the FIB.
- `rx_drop`  out  1  one-cycle pulse when a packet is discarded.
- `rx_busy`  out  1  high while any buffer holds an undrained packet.

## Operation
- Synchronize SPI inputs through `SYNC_STAGES` flops, then detect rising edges of `spi_sclk` on the synchronized signal.
- The bit counter runs 0..7 and shifts `mosi` in MSB first. At count 8 it writes the byte into the fill buffer at the current byte index.
- Byte 0 is the metadata byte. The packet length is latched from byte 0: if bit `DATA_FLAG_BIT` is 1, the length is 41 (8b meta + 64b prefix + 256b data); otherwise it is 9 (8b meta + 64b prefix).
- When byte index reaches the latched length, mark the fill buffer full and swap to the other buffer. `spi_cs_n` may stay low, and the next byte starts a new packet.
- If `spi_cs_n` goes high (synchronized) mid-byte or mid-packet, discard the partial packet, clear the counters, and pulse `rx_drop`. Deasserting `spi_cs_n` at an exact packet boundary is not a drop.
- If byte 0 of a new packet completes while the other buffer is still full or draining, drop the whole incoming packet and pulse `rx_drop` once. Ignore bytes until `spi_cs_n` deasserts or the dropped length elapses.
- Drain FSM states:
  - IDLE: if any buffer is full, go to STROBE, selecting the older buffer first.
  - STROBE: `RX_valid`=1 for one cycle, then go to SEND.
  - SEND: output one byte per cycle, indices 0..len-1, then free the buffer and go to IDLE.
- `data_SPI_to_FIB` is 0 in IDLE and STROBE. `RX_valid` is 0 in SEND.

## Timing
- Reset values: `RX_valid`=0, `data_SPI_to_FIB`=0, `rx_drop`=0, `rx_busy`=0. Both buffers are marked empty, the FSM is in IDLE, and all counters are 0.
- Reset takes effect at the next `clk` edge, including in the middle of SPI reception or a burst. After reset the burst stops and no further bytes are emitted.
- `spi_sclk` high and low phases must each be at least `SYNC_STAGES`+1 `clk` cycles.
- If `RX_valid` is high in cycle t, byte k is on `data_SPI_to_FIB` in cycle t+1+k. The burst is gapless.
- The first IDLE→STROBE transition happens one cycle after the buffer is marked full.
- A burst takes len+1 cycles. After the last byte there is one IDLE cycle before the next strobe.
- Completion and drain may occur in the same cycle. In that case the full-mark and the buffer-free both take effect, with no loss.

## Structure
- Shared package `ndn_pkg` holds:
  - constants `META_W`=8, `PREFIX_W`=64, `DATA_W`=256, `INTEREST_BYTES`=9, `DATA_BYTES`=41;
  - the drain-FSM state enum.
- One sub-module, `spi_byte_rx`, contains the synchronizer, edge detect and shift register. It outputs `byte_valid`, `byte`, and `cs_abort`.
- The top level holds the ping-pong buffers (2×41 bytes), the length latch and the drain FSM.

## Test plan
- Interest packet: meta 0x30, prefix 0x0000FFFF0000FFFF, sent over SPI. Expect `RX_valid` for one cycle, then exactly 30 00 00 FF FF 00 00 FF FF on consecutive cycles, then 0.
- Data packet: meta 0x80, prefix 0x0123456789ABCDEF, data incrementing from 0x00 to 0x1F. Expect one strobe and 41 bytes in order, with the last byte 0x1F.
- Mid-byte abort: `spi_cs_n` rises after 5 bits of byte 3. Expect `rx_drop` to pulse once and no `RX_valid`. Then send an interest packet and expect it to be delivered intact.
- Back-to-back: two interest packets with `spi_cs_n` held low. Expect two strobes with bursts in order, and `rx_busy` high from the first completion until the last byte is drained.
- Reset mid-burst: assert `rst` at byte 4 of a data-packet burst. Expect the outputs to be 0 on the next cycle, `rx_busy`=0, and no residual strobe afterwards.
